board_sprite_scanner: RTL
=========================

Name: board_sprite_scanner

Overview:
- Upstream stage of the 55x55 piece-sprite renderers; holds the 8x8 board state and drives their offsetX/offsetY inputs.
- Per pixel, decodes DrawX/DrawY into a board square and outputs that square's sprite origin combinationally.
- Also outputs the square's piece code, light/dark colour and cursor hit, registered one cycle to line up with the renderers' registered RGB.
- Owns a move-command handshake FSM that updates the board between frames (legality is checked upstream).

Parameters:
BOARD_X0, 100, left pixel of square column 0
BOARD_Y0, 20, top pixel of square row 0
SQ_DIM, 55, square edge in pixels; equals the sprite dimension

Ports:
vga_clk  in  1  pixel clock; all state updates on posedge
Reset  in  1  asynchronous, active-high reset
DrawX  in  10  current pixel column
DrawY  in  10  current pixel row
offsetX  out  10  combinational: BOARD_X0 + col*SQ_DIM of the square under DrawX; 0 when off-board
offsetY  out  10  combinational: BOARD_Y0 + row*SQ_DIM; 0 when off-board
on_board  out  1  registered: previous pixel was inside the board
piece_code  out  4  registered: piece on that square; 0 when off-board
light_sq  out  1  registered: (row+col) even
cursor_hit  out  1  registered: square equals {cur_row,cur_col}
cur_row  in  3  cursor row, 0 = top
cur_col  in  3  cursor column, 0 = left
mv_valid  in  1  move request
mv_ready  out  1  FSM is in IDLE
mv_src  in  6  source square, row*8+col
mv_dst  in  6  destination square
mv_done  out  1  one-cycle completion pulse
mv_err  out  1  valid only with mv_done; move rejected
mv_captured  out  4  valid with mv_done; previous dst content (0 = none)

Behaviour:
- Reset, asynchronous: outputs are 0, board loads the standard start position.
  - Row 0: black R N B Q K B N R. Row 1: black pawns.
  - Row 6: white pawns. Row 7: white R N B Q K B N R.
  - All other squares empty.
  - FSM enters IDLE with mv_ready=1.
- Piece encoding: 0 empty; 1-6 white P N B R Q K; 9-14 black P N B R Q K; bit3 = black. Codes 7, 8 and 15 are never stored.
- Square decode:
  - col = k when BOARD_X0 + k*SQ_DIM <= DrawX < BOARD_X0 + (k+1)*SQ_DIM, for k = 0..7. Rows decode the same way from DrawY.
  - Implemented as a comparator chain; no dividers.
  - Inside = both coordinates in [origin, origin + 8*SQ_DIM - 1].
  - Board pixels 100..539 (X) and 20..459 (Y) at defaults.
- Pixel pipeline:
  - offsetX/offsetY are combinational from DrawX/DrawY, latency 0.
  - on_board, piece_code, light_sq and cursor_hit register on posedge, latency 1.
  - When off-board the registered outputs are all 0, including light_sq and cursor_hit.
- Move FSM: IDLE -> LOAD -> WRITE -> DONE -> IDLE.
  - IDLE: accept the request when mv_valid && mv_ready. Latch src, dst and tmp=board[src].
  - LOAD: err = (tmp==0) || (src==dst). cap = board[dst].
  - WRITE: if no error, board[dst]<=tmp and board[src]<=0. If error, no board write.
  - DONE: mv_done=1 for exactly one cycle; mv_err and mv_captured driven; mv_ready=0.
  - Back in IDLE, mv_ready returns to 1. Minimum 4 cycles per move.
  - mv_valid outside IDLE is ignored; no queuing.
- Board writes take effect in the WRITE cycle. Pixel reads see the new value from the next cycle on; mid-frame tearing is acceptable.
- mv_captured is 0 when mv_err=1.
- Reset asserted mid-move aborts the move, restores the start position and suppresses mv_done.
- cur_row/cur_col are sampled every pixel with no latching.

Decomposition:
- chess_pkg holds:
  - piece_t as a 4-bit enum: EMPTY, W_PAWN..W_KING = 1..6, B_PAWN..B_KING = 9..14.
  - Constants: SQ_DIM, BOARD_X0, BOARD_Y0, and the start-position array.
  - mv_state_t: IDLE, LOAD, WRITE, DONE.
- Sub-module board_coord_decode: the combinational DrawX/DrawY -> {inside, row, col, offsetX, offsetY} comparator chain, instantiated once.

Test Plan:
- Reset deasserted, DrawX=100, DrawY=20 -> offsetX=100, offsetY=20; next cycle on_board=1, piece_code=12 (black rook), light_sq=1.
- DrawX=539, DrawY=459 -> offset (485,405); next cycle piece_code=4 (white rook). DrawX=540 -> offsets 0; next cycle on_board=0, piece_code=0.
- Move src=52 (e2), dst=36 (e4):
  - mv_ready drops after acceptance; mv_done pulses 3 cycles later with mv_err=0, mv_captured=0.
  - Pixel at square 36 then reads 1; square 52 reads 0.
- Move src=36, dst=36 -> mv_done with mv_err=1, board unchanged. Move from empty square 40 -> mv_err=1.
- Capture: preload by moving 8 -> 44, then move 52 -> 44 -> mv_captured=9, board[44]=1, board[52]=0.
- Reset pulsed during the LOAD state -> no mv_done, mv_ready=1 after release, board back to the start position.

Source files
------------

// File: rtl/chess_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | chess_pkg: piece encoding, board geometry and start position for the      |
// | board sprite scanner.                                                      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package chess_pkg;

  localparam int SQ_DIM   = 55;
  localparam int BOARD_X0 = 100;
  localparam int BOARD_Y0 = 20;

  // bit3 marks a black piece; 7, 8 and 15 are never stored
  typedef enum logic [3:0] {
    EMPTY    = 4'd0,
    W_PAWN   = 4'd1,
    W_KNIGHT = 4'd2,
    W_BISHOP = 4'd3,
    W_ROOK   = 4'd4,
    W_QUEEN  = 4'd5,
    W_KING   = 4'd6,
    B_PAWN   = 4'd9,
    B_KNIGHT = 4'd10,
    B_BISHOP = 4'd11,
    B_ROOK   = 4'd12,
    B_QUEEN  = 4'd13,
    B_KING   = 4'd14
  } piece_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } mv_state_t;

  localparam piece_t c_START_POS [64] = '{
    B_ROOK, B_KNIGHT, B_BISHOP, B_QUEEN, B_KING, B_BISHOP, B_KNIGHT, B_ROOK,
    B_PAWN, B_PAWN,   B_PAWN,   B_PAWN,  B_PAWN, B_PAWN,   B_PAWN,   B_PAWN,
    EMPTY,  EMPTY,    EMPTY,    EMPTY,   EMPTY,  EMPTY,    EMPTY,    EMPTY,
    EMPTY,  EMPTY,    EMPTY,    EMPTY,   EMPTY,  EMPTY,    EMPTY,    EMPTY,
    EMPTY,  EMPTY,    EMPTY,    EMPTY,   EMPTY,  EMPTY,    EMPTY,    EMPTY,
    EMPTY,  EMPTY,    EMPTY,    EMPTY,   EMPTY,  EMPTY,    EMPTY,    EMPTY,
    W_PAWN, W_PAWN,   W_PAWN,   W_PAWN,  W_PAWN, W_PAWN,   W_PAWN,   W_PAWN,
    W_ROOK, W_KNIGHT, W_BISHOP, W_QUEEN, W_KING, W_BISHOP, W_KNIGHT, W_ROOK
  };

  // (row+col) even is a light square
  function automatic logic is_light(input logic [2:0] row, input logic [2:0] col);
    return row[0] == col[0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/board_coord_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | board_coord_decode: comparator-chain decode of a pixel position into a     |
// | board square and that square's sprite origin.                              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module board_coord_decode
  import chess_pkg::*;
#(
  parameter int ORIGIN_X = BOARD_X0,
  parameter int ORIGIN_Y = BOARD_Y0,
  parameter int DIM      = SQ_DIM
) (
  input  logic [9:0] i_draw_x,
  input  logic [9:0] i_draw_y,
  output logic       o_inside,
  output logic [2:0] o_row,
  output logic [2:0] o_col,
  output logic [9:0] o_offset_x,
  output logic [9:0] o_offset_y
);

  logic [8:0] w_ge_x;
  logic [8:0] w_ge_y;
  logic [2:0] w_col;
  logic [2:0] w_row;
  logic [9:0] w_org_x;
  logic [9:0] w_org_y;
  logic       w_inside;

  // w_ge_*[k] is set once the pixel has reached square edge k (edge 8 is past the board)
  generate
    for (genvar k = 0; k < 9; k++) begin : g_edge
      assign w_ge_x[k] = i_draw_x >= 10'(ORIGIN_X + k * DIM);
      assign w_ge_y[k] = i_draw_y >= 10'(ORIGIN_Y + k * DIM);
    end
  endgenerate

  always_comb begin
    w_col   = 3'd0;
    w_row   = 3'd0;
    w_org_x = 10'(ORIGIN_X);
    w_org_y = 10'(ORIGIN_Y);
    for (int k = 1; k < 8; k++) begin
      if (w_ge_x[k]) begin
        w_col   = 3'(k);
        w_org_x = 10'(ORIGIN_X + k * DIM);
      end
      if (w_ge_y[k]) begin
        w_row   = 3'(k);
        w_org_y = 10'(ORIGIN_Y + k * DIM);
      end
    end
  end

  assign w_inside   = w_ge_x[0] & ~w_ge_x[8] & w_ge_y[0] & ~w_ge_y[8];
  assign o_inside   = w_inside;
  assign o_row      = w_row;
  assign o_col      = w_col;
  assign o_offset_x = w_inside ? w_org_x : 10'd0;
  assign o_offset_y = w_inside ? w_org_y : 10'd0;

endmodule
`default_nettype wire

// File: rtl/board_sprite_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | board_sprite_scanner: holds the 8x8 board, feeds sprite origins and square |
// | attributes to the piece renderers, and applies move commands.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module board_sprite_scanner #(
  parameter int BOARD_X0 = chess_pkg::BOARD_X0,
  parameter int BOARD_Y0 = chess_pkg::BOARD_Y0,
  parameter int SQ_DIM   = chess_pkg::SQ_DIM
) (
  input  logic       vga_clk,
  input  logic       Reset,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic [9:0] offsetX,
  output logic [9:0] offsetY,
  output logic       on_board,
  output logic [3:0] piece_code,
  output logic       light_sq,
  output logic       cursor_hit,
  input  logic [2:0] cur_row,
  input  logic [2:0] cur_col,
  input  logic       mv_valid,
  output logic       mv_ready,
  input  logic [5:0] mv_src,
  input  logic [5:0] mv_dst,
  output logic       mv_done,
  output logic       mv_err,
  output logic [3:0] mv_captured
);

  import chess_pkg::*;

  logic       w_inside;
  logic [2:0] w_row;
  logic [2:0] w_col;

  piece_t     r_board [64];
  mv_state_t  r_state;
  logic [5:0] r_src;
  logic [5:0] r_dst;
  piece_t     r_tmp;
  piece_t     r_cap;
  logic       r_err;

  board_coord_decode #(
    .ORIGIN_X (BOARD_X0),
    .ORIGIN_Y (BOARD_Y0),
    .DIM      (SQ_DIM)
  ) u_decode (
    .i_draw_x   (DrawX),
    .i_draw_y   (DrawY),
    .o_inside   (w_inside),
    .o_row      (w_row),
    .o_col      (w_col),
    .o_offset_x (offsetX),
    .o_offset_y (offsetY)
  );

  // Registered square attributes line up with the renderers' registered RGB
  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      on_board   <= 1'b0;
      piece_code <= 4'd0;
      light_sq   <= 1'b0;
      cursor_hit <= 1'b0;
    end else begin
      on_board   <= w_inside;
      piece_code <= w_inside ? r_board[{w_row, w_col}] : 4'd0;
      light_sq   <= w_inside & is_light(w_row, w_col);
      cursor_hit <= w_inside & (w_row == cur_row) & (w_col == cur_col);
    end
  end

  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      r_state     <= IDLE;
      r_src       <= 6'd0;
      r_dst       <= 6'd0;
      r_tmp       <= EMPTY;
      r_cap       <= EMPTY;
      r_err       <= 1'b0;
      mv_ready    <= 1'b1;
      mv_done     <= 1'b0;
      mv_err      <= 1'b0;
      mv_captured <= 4'd0;
      for (int i = 0; i < 64; i++) begin
        r_board[i] <= c_START_POS[i];
      end
    end else begin
      mv_done     <= 1'b0;
      mv_err      <= 1'b0;
      mv_captured <= 4'd0;
      case (r_state)
        IDLE: begin
          if (mv_valid && mv_ready) begin
            r_src    <= mv_src;
            r_dst    <= mv_dst;
            r_tmp    <= r_board[mv_src];
            mv_ready <= 1'b0;
            r_state  <= LOAD;
          end
        end
        LOAD: begin
          r_err   <= (r_tmp == EMPTY) || (r_src == r_dst);
          r_cap   <= r_board[r_dst];
          r_state <= WRITE;
        end
        WRITE: begin
          if (!r_err) begin
            r_board[r_dst] <= r_tmp;
            r_board[r_src] <= EMPTY;
          end
          mv_done     <= 1'b1;
          mv_err      <= r_err;
          mv_captured <= r_err ? 4'd0 : r_cap;
          r_state     <= DONE;
        end
        DONE: begin
          mv_ready <= 1'b1;
          r_state  <= IDLE;
        end
        default: begin
          mv_ready <= 1'b1;
          r_state  <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
